// File: rtl/exu_sched_pkg.sv
// Shared op-class codes, FSM state encodings and writeback-select encodings for exu_sched.
// Also provides the helper functions that decode an ALU op into its scheduling class.
package exu_sched_pkg;

    localparam int ALUOP_WIDTH = 5;
    typedef logic [ALUOP_WIDTH-1:0] aluop_t;

    localparam aluop_t OP_MUL  = 5'd15;
    localparam aluop_t OP_DIV  = 5'd16;
    localparam aluop_t OP_DIVU = 5'd17;
    localparam aluop_t OP_REM  = 5'd18;
    localparam aluop_t OP_REMU = 5'd19;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MUL_WAIT = 2'd1;
    localparam logic [1:0] ST_DIV_WAIT = 2'd2;
    localparam logic [1:0] ST_WB       = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MUL = 2'd1;
    localparam logic [1:0] WB_QUO = 2'd2;
    localparam logic [1:0] WB_REM = 2'd3;

    typedef enum logic [1:0] {CLS_SINGLE, CLS_MUL, CLS_DIV} op_cls_t;

    function automatic op_cls_t op_class(input aluop_t op);
        case (op)
            OP_MUL:                             op_class = CLS_MUL;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU:   op_class = CLS_DIV;
            default:                            op_class = CLS_SINGLE;
        endcase
    endfunction

    function automatic logic op_is_signed(input aluop_t op);
        op_is_signed = (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input aluop_t op);
        op_is_rem = (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/exu_sched_if.sv
// Issue/unit/writeback handshake bundle between the scheduler and its neighbours.
// The slave modport is the scheduler's view; master is the surrounding pipeline and units.
interface exu_sched_if import exu_sched_pkg::*; ();

    logic       issue_valid;
    logic       issue_ready;
    aluop_t     issue_op;
    logic       flush;
    logic       mul_start;
    logic       div_start;
    logic       div_signed;
    logic       unit_kill;
    logic       mul_done;
    logic       div_done;
    logic       wb_valid;
    logic [1:0] wb_sel;
    logic       wb_ready;
    logic       busy;
    logic       timeout_err;

    modport master (
        output issue_valid, issue_op, flush, mul_done, div_done, wb_ready,
        input  issue_ready, mul_start, div_start, div_signed, unit_kill,
               wb_valid, wb_sel, busy, timeout_err
    );

    modport slave (
        input  issue_valid, issue_op, flush, mul_done, div_done, wb_ready,
        output issue_ready, mul_start, div_start, div_signed, unit_kill,
               wb_valid, wb_sel, busy, timeout_err
    );

endinterface

// File: rtl/exu_sched_wdog.sv
// Wait-state watchdog: counter cleared on wait entry, counts wait cycles, flags the last one.
// expired is combinational from the count; it has no handshake of its own.
module exu_sched_wdog #(
    parameter int TIMEOUT = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // count_q holds (wait cycles already spent), so TIMEOUT-1 marks the TIMEOUT-th wait cycle
    assign expired = en && (count_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/exu_sched.sv
// Execute-stage scheduler for single-cycle ALU ops and multi-cycle MUL/DIV units.
// Result appears one cycle after accept/done; issue stalls while wb_valid waits on wb_ready.
module exu_sched import exu_sched_pkg::*; #(
    parameter int TIMEOUT = 100
) (
    input  logic         clk,
    input  logic         rst,
    exu_sched_if.slave   io
);

    logic [1:0] state_q, state_d;
    logic [1:0] wb_sel_q, wb_sel_d;
    logic       mul_start_q, mul_start_d;
    logic       div_start_q, div_start_d;
    logic       div_signed_q, div_signed_d;
    logic       unit_kill_q, unit_kill_d;
    logic       rem_q, rem_d;
    logic       timeout_err_q, timeout_err_d;

    logic       issue_ready;
    logic       accept;
    logic       in_wait;
    logic       wait_entry;
    logic       expired;

    assign in_wait     = (state_q == ST_MUL_WAIT) || (state_q == ST_DIV_WAIT);
    assign issue_ready = !io.flush && ((state_q == ST_IDLE) || ((state_q == ST_WB) && io.wb_ready));
    assign accept      = io.issue_valid && issue_ready;

    always_comb begin
        state_d       = state_q;
        wb_sel_d      = wb_sel_q;
        mul_start_d   = 1'b0;
        div_start_d   = 1'b0;
        div_signed_d  = 1'b0;
        unit_kill_d   = 1'b0;
        rem_d         = rem_q;
        timeout_err_d = timeout_err_q;
        wait_entry    = 1'b0;

        if (io.flush) begin
            // Flush beats done and timeout; units only need killing if they are running
            state_d     = ST_IDLE;
            unit_kill_d = in_wait;
        end else if (accept) begin
            case (op_class(io.issue_op))
                CLS_MUL: begin
                    state_d     = ST_MUL_WAIT;
                    mul_start_d = 1'b1;
                    wait_entry  = 1'b1;
                end
                CLS_DIV: begin
                    state_d      = ST_DIV_WAIT;
                    div_start_d  = 1'b1;
                    div_signed_d = op_is_signed(io.issue_op);
                    rem_d        = op_is_rem(io.issue_op);
                    wait_entry   = 1'b1;
                end
                default: begin
                    state_d  = ST_WB;
                    wb_sel_d = WB_ALU;
                end
            endcase
        end else begin
            case (state_q)
                ST_MUL_WAIT: begin
                    if (io.mul_done) begin
                        state_d  = ST_WB;
                        wb_sel_d = WB_MUL;
                    end else if (expired) begin
                        state_d       = ST_IDLE;
                        unit_kill_d   = 1'b1;
                        timeout_err_d = 1'b1;
                    end
                end
                ST_DIV_WAIT: begin
                    if (io.div_done) begin
                        state_d  = ST_WB;
                        wb_sel_d = rem_q ? WB_REM : WB_QUO;
                    end else if (expired) begin
                        state_d       = ST_IDLE;
                        unit_kill_d   = 1'b1;
                        timeout_err_d = 1'b1;
                    end
                end
                ST_WB: begin
                    if (io.wb_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wb_sel_q      <= WB_ALU;
            mul_start_q   <= 1'b0;
            div_start_q   <= 1'b0;
            div_signed_q  <= 1'b0;
            unit_kill_q   <= 1'b0;
            rem_q         <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wb_sel_q      <= wb_sel_d;
            mul_start_q   <= mul_start_d;
            div_start_q   <= div_start_d;
            div_signed_q  <= div_signed_d;
            unit_kill_q   <= unit_kill_d;
            rem_q         <= rem_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    exu_sched_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wait_entry),
        .en      (in_wait),
        .expired (expired)
    );

    assign io.issue_ready = issue_ready;
    assign io.mul_start   = mul_start_q;
    assign io.div_start   = div_start_q;
    assign io.div_signed  = div_signed_q;
    assign io.unit_kill   = unit_kill_q;
    assign io.wb_valid    = (state_q == ST_WB);
    assign io.wb_sel      = wb_sel_q;
    assign io.busy        = (state_q != ST_IDLE);
    assign io.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_exu_sched.sv
// Directed bench for exu_sched: inputs change 1ns after each rising edge, outputs checked 1-2ns after it.
module tb_exu_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    exu_sched_if ifc ();

    exu_sched #(.TIMEOUT(100)) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op);
        ifc.issue_valid = 1'b1;
        ifc.issue_op    = op;
        step();
        ifc.issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        n_chk++; if (ifc.busy !== 1'b0)        $display("FAIL rst_busy got=%b exp=0", ifc.busy); else n_pass++;
        n_chk++; if (ifc.wb_valid !== 1'b0)    $display("FAIL rst_wb_valid got=%b exp=0", ifc.wb_valid); else n_pass++;
        n_chk++; if (ifc.mul_start !== 1'b0)   $display("FAIL rst_mul_start got=%b exp=0", ifc.mul_start); else n_pass++;
        n_chk++; if (ifc.div_start !== 1'b0)   $display("FAIL rst_div_start got=%b exp=0", ifc.div_start); else n_pass++;
        n_chk++; if (ifc.unit_kill !== 1'b0)   $display("FAIL rst_unit_kill got=%b exp=0", ifc.unit_kill); else n_pass++;
        n_chk++; if (ifc.timeout_err !== 1'b0) $display("FAIL rst_timeout_err got=%b exp=0", ifc.timeout_err); else n_pass++;
        n_chk++; if (ifc.wb_sel !== 2'd0)      $display("FAIL rst_wb_sel got=%0d exp=0", ifc.wb_sel); else n_pass++;
        n_chk++; if (ifc.div_signed !== 1'b0)  $display("FAIL rst_div_signed got=%b exp=0", ifc.div_signed); else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        ifc.issue_valid = 1'b1;
        ifc.issue_op    = 5'd0;
        ifc.wb_ready    = 1'b1;
        #1;
        n_chk++; if (ifc.issue_ready !== 1'b1) $display("FAIL single_ready_idle got=%b exp=1", ifc.issue_ready); else n_pass++;
        step();
        #1;
        n_chk++; if (ifc.wb_valid !== 1'b1) $display("FAIL single_wb_valid got=%b exp=1", ifc.wb_valid); else n_pass++;
        n_chk++; if (ifc.wb_sel !== 2'd0)   $display("FAIL single_wb_sel got=%0d exp=0", ifc.wb_sel); else n_pass++;
        n_chk++; if (ifc.issue_ready !== 1'b1) $display("FAIL single_ready_wb got=%b exp=1", ifc.issue_ready); else n_pass++;
        step();
        ifc.issue_valid = 1'b0;
        n_chk++; if (ifc.wb_valid !== 1'b1) $display("FAIL single_b2b_wb_valid got=%b exp=1", ifc.wb_valid); else n_pass++;
        step();
        n_chk++; if (ifc.busy !== 1'b0)     $display("FAIL single_idle_busy got=%b exp=0", ifc.busy); else n_pass++;
        n_chk++; if (ifc.wb_valid !== 1'b0) $display("FAIL single_idle_wb_valid got=%b exp=0", ifc.wb_valid); else n_pass++;
        ifc.wb_ready = 1'b0;
    endtask

    task automatic test_mul_b2b();
        ifc.wb_ready = 1'b0;
        issue(5'd15);
        n_chk++; if (ifc.mul_start !== 1'b1) $display("FAIL mul_start got=%b exp=1", ifc.mul_start); else n_pass++;
        n_chk++; if (ifc.div_start !== 1'b0) $display("FAIL mul_no_div_start got=%b exp=0", ifc.div_start); else n_pass++;
        n_chk++; if (ifc.busy !== 1'b1)      $display("FAIL mul_busy got=%b exp=1", ifc.busy); else n_pass++;
        ifc.div_done = 1'b1;
        step();
        ifc.div_done = 1'b0;
        n_chk++; if (ifc.mul_start !== 1'b0) $display("FAIL mul_start_pulse got=%b exp=0", ifc.mul_start); else n_pass++;
        n_chk++; if (ifc.wb_valid !== 1'b0)  $display("FAIL mul_stray_div_done got=%b exp=0", ifc.wb_valid); else n_pass++;
        ifc.mul_done = 1'b1;
        step();
        ifc.mul_done = 1'b0;
        n_chk++; if (ifc.wb_valid !== 1'b1) $display("FAIL mul_wb_valid got=%b exp=1", ifc.wb_valid); else n_pass++;
        n_chk++; if (ifc.wb_sel !== 2'd1)   $display("FAIL mul_wb_sel got=%0d exp=1", ifc.wb_sel); else n_pass++;
        ifc.wb_ready    = 1'b1;
        ifc.issue_valid = 1'b1;
        ifc.issue_op    = 5'd16;
        #1;
        n_chk++; if (ifc.issue_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", ifc.issue_ready); else n_pass++;
        step();
        ifc.issue_valid = 1'b0;
        ifc.wb_ready    = 1'b0;
        n_chk++; if (ifc.div_start !== 1'b1)  $display("FAIL b2b_div_start got=%b exp=1", ifc.div_start); else n_pass++;
        n_chk++; if (ifc.div_signed !== 1'b1) $display("FAIL b2b_div_signed got=%b exp=1", ifc.div_signed); else n_pass++;
        n_chk++; if (ifc.wb_valid !== 1'b0)   $display("FAIL b2b_wb_cleared got=%b exp=0", ifc.wb_valid); else n_pass++;
        ifc.div_done = 1'b1;
        step();
        ifc.div_done = 1'b0;
        n_chk++; if (ifc.wb_sel !== 2'd2)   $display("FAIL div_quo_wb_sel got=%0d exp=2", ifc.wb_sel); else n_pass++;
        ifc.wb_ready = 1'b1;
        step();
        ifc.wb_ready = 1'b0;
        n_chk++; if (ifc.busy !== 1'b0)     $display("FAIL div_quo_idle got=%b exp=0", ifc.busy); else n_pass++;
    endtask

    task automatic test_rem_hold();
        ifc.wb_ready = 1'b0;
        issue(5'd18);
        n_chk++; if (ifc.div_start !== 1'b1)  $display("FAIL rem_div_start got=%b exp=1", ifc.div_start); else n_pass++;
        n_chk++; if (ifc.div_signed !== 1'b1) $display("FAIL rem_div_signed got=%b exp=1", ifc.div_signed); else n_pass++;
        step();
        n_chk++; if (ifc.div_start !== 1'b0)  $display("FAIL rem_div_start_pulse got=%b exp=0", ifc.div_start); else n_pass++;
        repeat (4) step();
        ifc.div_done = 1'b1;
        step();
        ifc.div_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (ifc.wb_valid !== 1'b1)    $display("FAIL rem_hold_valid[%0d] got=%b exp=1", i, ifc.wb_valid); else n_pass++;
            n_chk++; if (ifc.wb_sel !== 2'd3)      $display("FAIL rem_hold_sel[%0d] got=%0d exp=3", i, ifc.wb_sel); else n_pass++;
            n_chk++; if (ifc.issue_ready !== 1'b0) $display("FAIL rem_hold_ready[%0d] got=%b exp=0", i, ifc.issue_ready); else n_pass++;
            step();
        end
        ifc.wb_ready = 1'b1;
        n_chk++; if (ifc.wb_sel !== 2'd3)   $display("FAIL rem_release_sel got=%0d exp=3", ifc.wb_sel); else n_pass++;
        step();
        ifc.wb_ready = 1'b0;
        n_chk++; if (ifc.wb_valid !== 1'b0) $display("FAIL rem_consumed got=%b exp=0", ifc.wb_valid); else n_pass++;
    endtask

    task automatic test_flush_done();
        issue(5'd15);
        step();
        ifc.flush    = 1'b1;
        ifc.mul_done = 1'b1;
        ifc.issue_valid = 1'b1;
        #1;
        n_chk++; if (ifc.issue_ready !== 1'b0) $display("FAIL flush_ready got=%b exp=0", ifc.issue_ready); else n_pass++;
        step();
        ifc.flush       = 1'b0;
        ifc.mul_done    = 1'b0;
        ifc.issue_valid = 1'b0;
        n_chk++; if (ifc.wb_valid !== 1'b0)  $display("FAIL flush_done_wb got=%b exp=0", ifc.wb_valid); else n_pass++;
        n_chk++; if (ifc.unit_kill !== 1'b1) $display("FAIL flush_done_kill got=%b exp=1", ifc.unit_kill); else n_pass++;
        n_chk++; if (ifc.busy !== 1'b0)      $display("FAIL flush_done_idle got=%b exp=0", ifc.busy); else n_pass++;
        step();
        n_chk++; if (ifc.unit_kill !== 1'b0) $display("FAIL flush_done_kill_pulse got=%b exp=0", ifc.unit_kill); else n_pass++;
        n_chk++; if (ifc.wb_valid !== 1'b0)  $display("FAIL flush_done_wb_late got=%b exp=0", ifc.wb_valid); else n_pass++;
    endtask

    task automatic test_flush_start();
        issue(5'd19);
        ifc.flush = 1'b1;
        n_chk++; if (ifc.div_start !== 1'b1) $display("FAIL flush_start_issued got=%b exp=1", ifc.div_start); else n_pass++;
        step();
        ifc.flush = 1'b0;
        n_chk++; if (ifc.unit_kill !== 1'b1) $display("FAIL flush_start_kill got=%b exp=1", ifc.unit_kill); else n_pass++;
        n_chk++; if (ifc.busy !== 1'b0)      $display("FAIL flush_start_idle got=%b exp=0", ifc.busy); else n_pass++;
        step();
        n_chk++; if (ifc.unit_kill !== 1'b0) $display("FAIL flush_start_kill_pulse got=%b exp=0", ifc.unit_kill); else n_pass++;
    endtask

    task automatic test_timeout();
        issue(5'd17);
        n_chk++; if (ifc.div_start !== 1'b1)  $display("FAIL to_div_start got=%b exp=1", ifc.div_start); else n_pass++;
        n_chk++; if (ifc.div_signed !== 1'b0) $display("FAIL to_div_unsigned got=%b exp=0", ifc.div_signed); else n_pass++;
        repeat (99) step();
        n_chk++; if (ifc.busy !== 1'b1)        $display("FAIL to_busy_at_100 got=%b exp=1", ifc.busy); else n_pass++;
        n_chk++; if (ifc.timeout_err !== 1'b0) $display("FAIL to_err_early got=%b exp=0", ifc.timeout_err); else n_pass++;
        step();
        n_chk++; if (ifc.timeout_err !== 1'b1) $display("FAIL to_err got=%b exp=1", ifc.timeout_err); else n_pass++;
        n_chk++; if (ifc.unit_kill !== 1'b1)   $display("FAIL to_kill got=%b exp=1", ifc.unit_kill); else n_pass++;
        n_chk++; if (ifc.busy !== 1'b0)        $display("FAIL to_idle got=%b exp=0", ifc.busy); else n_pass++;
        n_chk++; if (ifc.wb_valid !== 1'b0)    $display("FAIL to_no_wb got=%b exp=0", ifc.wb_valid); else n_pass++;
        step();
        n_chk++; if (ifc.unit_kill !== 1'b0)   $display("FAIL to_kill_pulse got=%b exp=0", ifc.unit_kill); else n_pass++;
        n_chk++; if (ifc.timeout_err !== 1'b1) $display("FAIL to_err_sticky got=%b exp=1", ifc.timeout_err); else n_pass++;
    endtask

    task automatic test_stray_reset();
        ifc.mul_done = 1'b1;
        step();
        ifc.mul_done = 1'b0;
        n_chk++; if (ifc.busy !== 1'b0)      $display("FAIL stray_busy got=%b exp=0", ifc.busy); else n_pass++;
        n_chk++; if (ifc.wb_valid !== 1'b0)  $display("FAIL stray_wb got=%b exp=0", ifc.wb_valid); else n_pass++;
        issue(5'd16);
        rst = 1'b1;
        #1;
        n_chk++; if (ifc.busy !== 1'b0)        $display("FAIL arst_busy got=%b exp=0", ifc.busy); else n_pass++;
        n_chk++; if (ifc.div_start !== 1'b0)   $display("FAIL arst_div_start got=%b exp=0", ifc.div_start); else n_pass++;
        n_chk++; if (ifc.div_signed !== 1'b0)  $display("FAIL arst_div_signed got=%b exp=0", ifc.div_signed); else n_pass++;
        n_chk++; if (ifc.timeout_err !== 1'b0) $display("FAIL arst_err got=%b exp=0", ifc.timeout_err); else n_pass++;
        n_chk++; if (ifc.wb_valid !== 1'b0)    $display("FAIL arst_wb got=%b exp=0", ifc.wb_valid); else n_pass++;
        repeat (2) step();
        n_chk++; if (ifc.unit_kill !== 1'b0)   $display("FAIL arst_no_kill got=%b exp=0", ifc.unit_kill); else n_pass++;
        rst = 1'b0;
        step();
        n_chk++; if (ifc.busy !== 1'b0)        $display("FAIL arst_after_busy got=%b exp=0", ifc.busy); else n_pass++;
        n_chk++; if (ifc.unit_kill !== 1'b0)   $display("FAIL arst_after_kill got=%b exp=0", ifc.unit_kill); else n_pass++;
    endtask

    initial begin
        ifc.issue_valid = 1'b0;
        ifc.issue_op    = 5'd0;
        ifc.flush       = 1'b0;
        ifc.mul_done    = 1'b0;
        ifc.div_done    = 1'b0;
        ifc.wb_ready    = 1'b0;
        test_reset();
        test_single();
        test_mul_b2b();
        test_rem_hold();
        test_flush_done();
        test_flush_start();
        test_timeout();
        test_stray_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exu_sched.md
EXU_SCHED -- requirements
Module: exu_sched

Interface
REQ-001 Parameter TIMEOUT, default 100: maximum cycles spent in a wait state before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 issue_valid  in  1  upstream offers one operation.
REQ-005 issue_ready  out  1  scheduler accepts the operation this cycle.
REQ-006 issue_op  in  ALUOP_WIDTH  operation code; sampled only on acceptance.
REQ-007 flush  in  1  pipeline redirect; kills the in-flight operation.
REQ-008 mul_start  out  1  one-cycle start pulse to the multiplier.
REQ-009 div_start  out  1  one-cycle start pulse to the divider.
REQ-010 div_signed  out  1  signed divide/remainder; valid while div_start=1.
REQ-011 unit_kill  out  1  one-cycle abort pulse to the multi-cycle units.
REQ-012 mul_done  in  1  multiplier result ready (pulse).
REQ-013 div_done  in  1  divider result ready (pulse).
REQ-014 wb_valid  out  1  result selected by wb_sel is available.
REQ-015 wb_sel  out  2  result source: 0 ALU/branch, 1 MUL, 2 DIV quotient, 3 REM.
REQ-016 wb_ready  in  1  downstream consumes the result.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 timeout_err  out  1  sticky; set on watchdog expiry.

Function
REQ-019 Op classes SHALL be: 15 MUL; 16 DIV signed; 17 DIV unsigned; 18 REM signed; 19 REM unsigned; all other codes SINGLE.
REQ-020 States SHALL be IDLE, MUL_WAIT, DIV_WAIT, WB.
REQ-021 issue_ready SHALL be 1 when flush=0 and either the state is IDLE or the state is WB with wb_ready=1.
REQ-022 Acceptance SHALL be issue_valid and issue_ready both high.
REQ-023 For a SINGLE op accepted in cycle N, the state SHALL be WB with wb_valid=1 and wb_sel=0 in cycle N+1.
REQ-024 For a MUL op accepted in cycle N, mul_start SHALL be 1 for cycle N+1 only and the state SHALL be MUL_WAIT.
REQ-025 For a DIV/REM op accepted in cycle N, div_start SHALL be 1 for cycle N+1 only, with div_signed=1 for ops 16 and 18; the state SHALL be DIV_WAIT.
REQ-026 In MUL_WAIT, mul_done=1 in cycle M SHALL give WB with wb_sel=1 in cycle M+1.
REQ-027 In DIV_WAIT, div_done=1 in cycle M SHALL give WB with wb_sel=2 for ops 16/17 and wb_sel=3 for ops 18/19 in cycle M+1.
REQ-028 wb_valid and wb_sel SHALL hold stable in WB until wb_ready=1.
REQ-029 When wb_ready=1 in WB, the next state SHALL be IDLE, unless a new op is accepted that cycle; in that case the op is handled as if accepted from IDLE (back-to-back).
REQ-030 A done pulse from a unit that is not being waited on SHALL be ignored.
REQ-031 flush=1 SHALL force IDLE next cycle from any state and clear wb_valid; unit_kill SHALL pulse for one cycle if the state was MUL_WAIT or DIV_WAIT.
REQ-032 When flush and done arrive in the same cycle, flush SHALL win and the result is dropped.
REQ-033 When flush and a start pulse coincide, the start pulse SHALL still be issued and unit_kill SHALL follow in the next cycle.
REQ-034 A wait-cycle counter SHALL clear on entry to MUL_WAIT/DIV_WAIT and increment each wait cycle.
REQ-035 When the counter reaches TIMEOUT without done, the block SHALL set timeout_err, pulse unit_kill, and return to IDLE next cycle with no writeback.

Reset
REQ-036 While rst=1, the state SHALL be IDLE; busy, wb_valid, mul_start, div_start, unit_kill and timeout_err SHALL be 0; wb_sel and div_signed SHALL be 0; the counter SHALL be 0.
REQ-037 Reset asserted mid-operation SHALL abandon the operation without a unit_kill pulse; the units are reset by the same rst.

Structure
REQ-038 The op-class codes (15–19), the state enum and the wb_sel encodings SHALL live in the shared parameter package alongside ALUOP_WIDTH.
REQ-039 The block SHALL contain one sub-module, exu_sched_wdog (the wait counter plus TIMEOUT compare); all else is inline.

Verification
REQ-040 Reset, then issue op 0 in cycle 1 with wb_ready=1 -> wb_valid=1, wb_sel=0 in cycle 2; with a new op held valid, issue_ready=1 in cycle 2.
REQ-041 Issue op 18, drive div_done 5 cycles after div_start, hold wb_ready=0 for 3 cycles -> div_signed=1, then wb_sel=3 stays stable until wb_ready.
REQ-042 Issue op 15, assert flush together with mul_done -> no wb_valid, unit_kill pulses once, IDLE next cycle.
REQ-043 Issue op 17 and never assert div_done -> after TIMEOUT=100 wait cycles, timeout_err=1 (sticky), unit_kill pulses once, busy=0.
REQ-044 Pulse mul_done in IDLE, then assert rst during DIV_WAIT -> no response to the stray done; all outputs 0 immediately, asynchronously.
